mem_unit: RTL

MEM_UNIT -- requirements
Module: mem_unit

---
 rtl/mem_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_unit.sv
// mem_unit: single-port word memory behind a fixed-latency request handshake.
//
// Accesses are accepted in IDLE, wait WAIT_CYCLES cycles, and then complete
// in a one-cycle DONE state. The read or write itself happens on the clock
// edge that enters DONE, so read data is already valid while mem_ready is high.
//
// Ports:
//   clk          : single clock, rising edge
//   rst_n        : synchronous active-low reset
//   mem_on       : access request (sampled only in IDLE)
//   mem_w        : 1 = write, 0 = read
//   mem_addr     : word address; bits at or above ADDR_BITS must be zero
//   mem_data_in  : write data
//   mem_data_out : read data, updated only when a read completes
//   mem_ready    : one-cycle completion pulse
//   mem_busy     : high from acceptance until completion
//   mem_err      : out-of-range flag, only ever high together with mem_ready
module mem_unit #(
  parameter int WORD_SIZE   = 32,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_on,
  input  logic                 mem_w,
  input  logic [WORD_SIZE-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0] mem_data_in,
  output logic [WORD_SIZE-1:0] mem_data_out,
  output logic                 mem_ready,
  output logic                 mem_busy,
  output logic                 mem_err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [3:0]             r_count;
  logic [3:0]             w_nextCount;
  logic                   w_accept;
  logic                   w_enterDone;

  logic                   r_write;
  logic [ADDR_BITS-1:0]   r_index;
  logic                   r_oob;
  logic [WORD_SIZE-1:0]   r_data;
  logic                   r_err;
  logic [WORD_SIZE-1:0]   r_dataOut;
  logic [WORD_SIZE-1:0]   r_mem [DEPTH];

  logic                   w_reqOob;
  logic                   w_accWrite;
  logic [ADDR_BITS-1:0]   w_accIndex;
  logic                   w_accOob;
  logic [WORD_SIZE-1:0]   w_accData;

  // Any address bit above the index field makes the request out of range.
  assign w_reqOob = (mem_addr >> ADDR_BITS) != '0;

  // With zero wait cycles the access is performed on the very edge that
  // accepts it, so the live inputs are used instead of the not-yet-loaded
  // capture registers. Otherwise the captured copy is used, which is what
  // makes mid-access input changes harmless.
  always_comb begin
    w_accWrite = r_write;
    w_accIndex = r_index;
    w_accOob   = r_oob;
    w_accData  = r_data;
    if (r_state == IDLE) begin
      w_accWrite = mem_w;
      w_accIndex = mem_addr[ADDR_BITS-1:0];
      w_accOob   = w_reqOob;
      w_accData  = mem_data_in;
    end
  end

  // Next-state logic. The counter is loaded with WAIT_CYCLES on acceptance
  // and DONE is entered on the cycle it steps from 1 to 0, which gives a
  // request-to-ready latency of exactly WAIT_CYCLES+1 cycles. DONE always
  // falls back to IDLE, so a held request re-arms only one cycle later.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_accept    = 1'b0;
    w_enterDone = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_on) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_nextState = DONE;
            w_enterDone = 1'b1;
          end else begin
            w_nextState = WAIT;
            w_nextCount = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        w_nextCount = r_count - 4'd1;
        if (r_count == 4'd1) begin
          w_nextState = DONE;
          w_enterDone = 1'b1;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State, counter and the visible result registers. Reset wins over any
  // request in the same cycle and abandons an access still in WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_dataOut <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      if (w_enterDone) begin
        r_err <= w_accOob;
        if (!w_accWrite) begin
          r_dataOut <= w_accOob ? '0 : r_mem[w_accIndex];
        end
      end
    end
  end

  // Request capture and storage. Neither is reset: storage keeps its
  // contents across reset, and the capture registers are only read after
  // a fresh acceptance has loaded them. Writes are gated by rst_n so an
  // access cut short by reset never reaches the array.
  always_ff @(posedge clk) begin
    if (rst_n && w_accept) begin
      r_write <= mem_w;
      r_index <= mem_addr[ADDR_BITS-1:0];
      r_oob   <= w_reqOob;
      r_data  <= mem_data_in;
    end
    if (rst_n && w_enterDone && w_accWrite && !w_accOob) begin
      r_mem[w_accIndex] <= w_accData;
    end
  end

  assign mem_data_out = r_dataOut;
  assign mem_ready    = (r_state == DONE);
  assign mem_busy     = (r_state != IDLE);
  assign mem_err      = (r_state == DONE) && r_err;

endmodule
